// File: rtl/risc521_sw_conditioner_pkg.sv
// Shared RISC521 switch-input constants, used by the core top level and the
// switch conditioner.
package risc521_sw_conditioner_pkg;

  localparam int RISC521_SW_W      = 5;
  localparam int RISC521_DB_CYCLES = 4;

  // Width needed to count 0..db_cycles-1, with one bit of headroom.
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles) + 1;
  endfunction

endpackage

// File: rtl/risc521_sw_conditioner_if.sv
// Switch bus between the board pins, the conditioner and the core's SW_in.
// The slave side is the conditioner; the master side is the consumer/driver.
interface risc521_sw_conditioner_if
  import risc521_sw_conditioner_pkg::*;
#(
  parameter int WIDTH = RISC521_SW_W
);

  logic [WIDTH-1:0] SW_raw;
  logic [WIDTH-1:0] SW_out;
  logic [WIDTH-1:0] SW_rise;
  logic [WIDTH-1:0] SW_fall;
  logic             SW_chg;

  modport master (output SW_raw, input SW_out, SW_rise, SW_fall, SW_chg);
  modport slave  (input SW_raw, output SW_out, SW_rise, SW_fall, SW_chg);

endinterface

// File: rtl/risc521_db_bit.sv
// One switch bit: two-flop synchroniser, saturating stability counter,
// and the registered level plus rise/fall pulses.
module risc521_db_bit #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic chg_d
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    out_d  = out_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // Any sample back at the current level restarts qualification.
    if (s2_q != out_q) begin
      if (cnt_q == LAST) begin
        out_d  = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out   = out_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign chg_d = rise_d | fall_d;

endmodule

// File: rtl/risc521_sw_conditioner.sv
// Debounces the raw board switches into the clean SW_in word for the core,
// with per-bit edge pulses and a registered any-change flag.
module risc521_sw_conditioner
  import risc521_sw_conditioner_pkg::*;
#(
  parameter int WIDTH     = RISC521_SW_W,
  parameter int DB_CYCLES = RISC521_DB_CYCLES
) (
  input  logic                     Clk,
  input  logic                     Reset,
  risc521_sw_conditioner_if.slave  sw
);

  localparam int CNT_W = db_cnt_w(DB_CYCLES);

  logic [WIDTH-1:0] out_w, rise_w, fall_w, chg_w;
  logic             chg_q, chg_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    risc521_db_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_bit (
      .clk   (Clk),
      .rst_n (Reset),
      .raw   (sw.SW_raw[i]),
      .out   (out_w[i]),
      .rise  (rise_w[i]),
      .fall  (fall_w[i]),
      .chg_d (chg_w[i])
    );
  end

  // Built from the bits' next-state pulses so the flag lands with them.
  always_comb chg_d = |chg_w;

  always_ff @(posedge Clk) begin
    if (!Reset) chg_q <= 1'b0;
    else        chg_q <= chg_d;
  end

  assign sw.SW_out  = out_w;
  assign sw.SW_rise = rise_w;
  assign sw.SW_fall = fall_w;
  assign sw.SW_chg  = chg_q;

endmodule

// File: tb/tb_risc521_sw_conditioner.sv
// Directed bench for the switch conditioner at DB_CYCLES=4, 40 ns clock.
module tb_risc521_sw_conditioner;

  localparam int W  = 5;
  localparam int DB = 4;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #20 Clk = ~Clk;

  risc521_sw_conditioner_if #(.WIDTH(W)) swif ();

  risc521_sw_conditioner #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sw    (swif)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Packed view {SW_out, SW_rise, SW_fall, SW_chg}
  logic [3*W:0] obs, exp_v;

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic hold_reset(input logic [W-1:0] raw);
    swif.SW_raw = raw;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    swif.SW_raw = 5'b11111;
    Reset = 1'b0;
    tick();
    obs = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
    vec_cnt++;
    if (obs !== '0) begin
      err_cnt++;
      $display("FAIL reset_clear got %h want 0", obs);
    end
    Reset = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 6) ? 5'b11111 : 5'b00000, (t == 6) ? 5'b11111 : 5'b00000,
               5'b00000, (t == 6)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL reset_release t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_clean_edge();
    hold_reset(5'b00000);
    tick();
    tick();
    swif.SW_raw = 5'b00100;
    for (int t = 1; t <= 8; t++) begin
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 6) ? 5'b00100 : 5'b00000, (t == 6) ? 5'b00100 : 5'b00000,
               5'b00000, (t == 6)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL clean_edge t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    hold_reset(5'b00000);
    swif.SW_raw = 5'b00001;
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) swif.SW_raw = 5'b00000;
      tick();
      obs = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      vec_cnt++;
      if (obs !== '0) begin
        err_cnt++;
        $display("FAIL glitch t=%0d got %h want 0", t, obs);
      end
    end
    // Leftover count would shorten this latency below 6 edges.
    swif.SW_raw = 5'b00001;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 6) ? 5'b00001 : 5'b00000, (t == 6) ? 5'b00001 : 5'b00000,
               5'b00000, (t == 6)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL glitch_requal t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    hold_reset(5'b00000);
    // Raw 1,0,1,0,1 then held 1; stable run starts at edge 5, accepted at edge 10.
    for (int t = 1; t <= 12; t++) begin
      swif.SW_raw = (t > 5 || (t % 2) == 1) ? 5'b00010 : 5'b00000;
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 10) ? 5'b00010 : 5'b00000, (t == 10) ? 5'b00010 : 5'b00000,
               5'b00000, (t == 10)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL bounce t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    hold_reset(5'b00100);
    for (int t = 1; t <= 7; t++) tick();
    obs = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
    vec_cnt++;
    if (obs !== {5'b00100, 5'b00000, 5'b00000, 1'b0}) begin
      err_cnt++;
      $display("FAIL simul_setup got %h want %h", obs, {5'b00100, 11'd0});
    end
    swif.SW_raw = 5'b10001;
    for (int t = 1; t <= 8; t++) begin
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 6) ? 5'b10001 : 5'b00100, (t == 6) ? 5'b10001 : 5'b00000,
               (t == 6) ? 5'b00100 : 5'b00000, (t == 6)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL simultaneous t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    hold_reset(5'b00000);
    swif.SW_raw = 5'b01000;
    for (int t = 1; t <= 4; t++) begin
      tick();
      obs = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      vec_cnt++;
      if (obs !== '0) begin
        err_cnt++;
        $display("FAIL reset_mid_pre t=%0d got %h want 0", t, obs);
      end
    end
    // Edge 5 would be the third counting edge.
    Reset = 1'b0;
    tick();
    obs = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
    vec_cnt++;
    if (obs !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid_clear got %h want 0", obs);
    end
    Reset = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      obs   = {swif.SW_out, swif.SW_rise, swif.SW_fall, swif.SW_chg};
      exp_v = {(t >= 6) ? 5'b01000 : 5'b00000, (t == 6) ? 5'b01000 : 5'b00000,
               5'b00000, (t == 6)};
      vec_cnt++;
      if (obs !== exp_v) begin
        err_cnt++;
        $display("FAIL reset_mid_requal t=%0d got %h want %h", t, obs, exp_v);
      end
    end
  endtask

  initial begin
    swif.SW_raw = '0;
    @(negedge Clk);
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
